// File: rtl/clkdvd_pkg.sv
// rtl/clkdvd_pkg.sv - shared types, select encodings and Gray step function for the clock divider
package clkdvd_pkg;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam sel_t SEL_DIV2  = 2'b00;
    localparam sel_t SEL_DIV4  = 2'b01;
    localparam sel_t SEL_DIV16 = 2'b11;
    localparam sel_t SEL_DIV8  = 2'b10;

    // Auto sequencer walks the selects in Gray order so one bit flips per step.
    function automatic sel_t next_sel(input sel_t s);
        case (s)
            SEL_DIV2:  next_sel = SEL_DIV4;
            SEL_DIV4:  next_sel = SEL_DIV16;
            SEL_DIV16: next_sel = SEL_DIV8;
            default:   next_sel = SEL_DIV2;
        endcase
    endfunction

endpackage

// File: rtl/clkdvd_core.sv
// rtl/clkdvd_core.sv - half-period counter, divided output and period-boundary/tick generation
module clkdvd_core
    import clkdvd_pkg::*;
#(
    parameter int BASE_SHIFT = 0
) (
    input  logic clk,
    input  logic rst,
    input  sel_t sel,
    output logic out,
    output logic tick,
    output logic pb
);

    localparam int CW = 4 + BASE_SHIFT;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_m1;
    logic          out_q, out_d;
    logic          tick_q, tick_d;
    logic          at_end;

    // A select change is only applied at pb, where cnt and out wrap to zero
    // anyway, so the new half-period starts cleanly with no special load path.
    always_comb begin
        half_m1 = (CW'(1) << (32'(sel) + BASE_SHIFT)) - CW'(1);
        at_end  = (cnt_q == half_m1);
        pb      = at_end && out_q;
        cnt_d   = at_end ? '0 : cnt_q + CW'(1);
        out_d   = at_end ? ~out_q : out_q;
        tick_d  = pb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
        end
    end

    assign out  = out_q;
    assign tick = tick_q;

endmodule

// File: rtl/clkdvd_ctrl.sv
// rtl/clkdvd_ctrl.sv - rate controller (request port, auto sequencer) around clkdvd_core; CLKDVD_CTRL_SWCNT_EN adds sw_count
module clkdvd_ctrl
    import clkdvd_pkg::*;
#(
    parameter sel_t RST_SEL    = 2'b00,
    parameter int   BASE_SHIFT = 0,
    parameter int   DWELL_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [1:0]         req_sel,
    output logic               req_ready,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         cur_sel,
    output logic               busy,
`ifdef CLKDVD_CTRL_SWCNT_EN
    output logic [15:0]        sw_count,
`endif
    output logic               tick,
    output logic               out
);

    state_t             state_q, state_d;
    sel_t               cur_sel_q, cur_sel_d;
    sel_t               pend_sel_q, pend_sel_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [DWELL_W-1:0] dwell_m1;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               accept;
    logic               pb;
`ifdef CLKDVD_CTRL_SWCNT_EN
    logic [15:0]        sw_count_q, sw_count_d;
`endif

    clkdvd_core #(
        .BASE_SHIFT(BASE_SHIFT)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .sel (cur_sel_q),
        .out (out),
        .tick(tick),
        .pb  (pb)
    );

    // req_ready is registered, so a request offered in the cycle auto_en
    // rises is still accepted and runs to completion through PEND.
    assign accept   = req_valid && req_ready_q;
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        dcnt_d     = auto_en ? dcnt_q : '0;
`ifdef CLKDVD_CTRL_SWCNT_EN
        sw_count_d = sw_count_q;
`endif
        case (state_q)
            RUN: begin
                if (accept && (req_sel != cur_sel_q)) begin
                    pend_sel_d = req_sel;
                    state_d    = PEND;
                end else if (auto_en && pb) begin
                    if (dcnt_q == dwell_m1) begin
                        pend_sel_d = next_sel(cur_sel_q);
                        cur_sel_d  = next_sel(cur_sel_q);
                        dcnt_d     = '0;
`ifdef CLKDVD_CTRL_SWCNT_EN
                        sw_count_d = sw_count_q + 16'd1;
`endif
                    end else begin
                        dcnt_d = dcnt_q + DWELL_W'(1);
                    end
                end
            end
            PEND: begin
                if (pb) begin
                    cur_sel_d = pend_sel_q;
                    state_d   = RUN;
`ifdef CLKDVD_CTRL_SWCNT_EN
                    sw_count_d = sw_count_q + 16'd1;
`endif
                end
            end
            default: state_d = RUN;
        endcase
        busy_d      = (state_d == PEND);
        req_ready_d = (state_d == RUN) && !auto_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cur_sel_q   <= RST_SEL;
            pend_sel_q  <= RST_SEL;
            dcnt_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CLKDVD_CTRL_SWCNT_EN
            sw_count_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_sel_q   <= cur_sel_d;
            pend_sel_q  <= pend_sel_d;
            dcnt_q      <= dcnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
`ifdef CLKDVD_CTRL_SWCNT_EN
            sw_count_q  <= sw_count_d;
`endif
        end
    end

    assign cur_sel   = cur_sel_q;
    assign busy      = busy_q;
    assign req_ready = req_ready_q;
`ifdef CLKDVD_CTRL_SWCNT_EN
    assign sw_count  = sw_count_q;
`endif

endmodule

// File: tb/tb_clkdvd_ctrl.sv
// tb/tb_clkdvd_ctrl.sv - randomized bench for clkdvd_ctrl against a period-position reference model
module tb_clkdvd_ctrl;

    localparam logic [1:0] RST_SEL    = 2'b00;
    localparam int         BASE_SHIFT = 0;
    localparam int         DWELL_W    = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic [1:0]         req_sel;
    logic               req_ready;
    logic               auto_en;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         cur_sel;
    logic               busy;
    logic               tick;
    logic               out;
`ifdef CLKDVD_CTRL_SWCNT_EN
    logic [15:0]        sw_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position inside the current output period.
    int m_pos, m_sel, m_psel, m_dcnt, m_swc;
    bit m_pend, m_ready, m_tick;
    int gray_next [4] = '{1, 3, 0, 2};

    clkdvd_ctrl #(
        .RST_SEL   (RST_SEL),
        .BASE_SHIFT(BASE_SHIFT),
        .DWELL_W   (DWELL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .auto_en  (auto_en),
        .dwell    (dwell),
        .cur_sel  (cur_sel),
        .busy     (busy),
`ifdef CLKDVD_CTRL_SWCNT_EN
        .sw_count (sw_count),
`endif
        .tick     (tick),
        .out      (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int half_of(input int s);
        return 1 << (s + BASE_SHIFT);
    endfunction

    task automatic model_step();
        int  half, dw, new_pos;
        bit  pb, acc;
        if (rst) begin
            m_pos = 0; m_sel = int'(RST_SEL); m_psel = int'(RST_SEL);
            m_dcnt = 0; m_swc = 0; m_pend = 0; m_ready = 0; m_tick = 0;
        end else begin
            half    = half_of(m_sel);
            pb      = (m_pos == 2 * half - 1);
            acc     = req_valid && m_ready;
            new_pos = pb ? 0 : m_pos + 1;
            if (m_pend) begin
                if (pb) begin
                    m_sel  = m_psel;
                    m_pend = 0;
                    m_swc  = (m_swc + 1) % 65536;
                end
            end else if (acc && (int'(req_sel) != m_sel)) begin
                m_pend = 1;
                m_psel = int'(req_sel);
            end else if (auto_en && pb) begin
                dw = (dwell == 0) ? 1 : int'(dwell);
                if (m_dcnt == dw - 1) begin
                    m_sel  = gray_next[m_sel];
                    m_dcnt = 0;
                    m_swc  = (m_swc + 1) % 65536;
                end else begin
                    m_dcnt = (m_dcnt + 1) % 65536;
                end
            end
            if (!auto_en) m_dcnt = 0;
            m_pos   = new_pos;
            m_tick  = pb;
            m_ready = !m_pend && !auto_en;
        end
    endtask

    task automatic check_all();
        check("out",       32'(out),       32'(m_pos >= half_of(m_sel)));
        check("tick",      32'(tick),      32'(m_tick));
        check("cur_sel",   32'(cur_sel),   32'(m_sel));
        check("busy",      32'(busy),      32'(m_pend));
        check("req_ready", 32'(req_ready), 32'(m_ready));
`ifdef CLKDVD_CTRL_SWCNT_EN
        check("sw_count",  32'(sw_count),  32'(m_swc));
`endif
    endtask

    // Apply one set of inputs for n cycles, checking after every edge.
    task automatic cyc(input bit r, input bit rv, input logic [1:0] rs,
                       input bit ae, input int dw, input int n);
        for (int i = 0; i < n; i++) begin
            rst = r; req_valid = rv; req_sel = rs; auto_en = ae; dwell = DWELL_W'(dw);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_sel = 2'b00; auto_en = 1'b0; dwell = '0;

        cyc(1, 0, 2'b00, 0, 0, 2);
        check("reset_out",   32'(out),       32'd0);
        check("reset_sel",   32'(cur_sel),   32'(RST_SEL));
        check("reset_ready", 32'(req_ready), 32'd0);
        cyc(0, 0, 2'b00, 0, 0, 8);

        // Slow down to /16, then back to /2 issued mid-period.
        cyc(0, 1, 2'b11, 0, 0, 1);
        check("req_busy", 32'(busy), 32'd1);
        cyc(0, 0, 2'b00, 0, 0, 24);
        cyc(0, 1, 2'b00, 0, 0, 1);
        cyc(0, 0, 2'b00, 0, 0, 20);

        // Request equal to the current select: accepted, never busy.
        cyc(0, 1, 2'b00, 0, 0, 1);
        check("noop_busy", 32'(busy), 32'd0);
        cyc(0, 0, 2'b00, 0, 0, 6);

        // Auto stepping with dwell 3, a stray request pulse, then dwell 0.
        cyc(0, 0, 2'b00, 1, 3, 60);
        cyc(0, 1, 2'b10, 1, 3, 1);
        cyc(0, 0, 2'b00, 1, 3, 200);
        cyc(0, 0, 2'b00, 0, 0, 4);
        cyc(0, 0, 2'b00, 1, 0, 80);
        cyc(0, 0, 2'b00, 0, 0, 20);

        // Reset while a change is pending.
        cyc(0, 1, 2'b11, 0, 0, 1);
        cyc(0, 1, 2'b01, 0, 0, 1);
        cyc(1, 0, 2'b00, 0, 0, 1);
        check("rst_pend_busy", 32'(busy),    32'd0);
        check("rst_pend_sel",  32'(cur_sel), 32'(RST_SEL));
        check("rst_pend_out",  32'(out),     32'd0);

        begin
            bit ae = 0;
            int dw = 2;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 79) == 0) ae = ~ae;
                if (!ae && $urandom_range(0, 19) == 0) dw = $urandom_range(0, 3);
                cyc($urandom_range(0, 399) == 0, $urandom_range(0, 5) == 0,
                    2'($urandom_range(0, 3)), ae, dw, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
